mmio_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares the single MMIO port of `mmio_xbar` between the CPU load/store unit (m0) and a second bus master such as a debug/DMA engine (m1). It latches the winning request, issues it to the crossbar for exactly one cycle, captures read data, and returns it to the owner. Both requesters see a simple req/gnt/rvalid handshake, and the crossbar never sees overlapping or partial accesses.

---
 rtl/mmio_arbiter_if.sv | 46 ++++
 rtl/mmio_arbiter.sv | 113 +++++++++++
 tb/tb_mmio_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mmio_arbiter_if.sv
// Requester/crossbar bundle for mmio_arbiter. The i_mX_lock wires exist only
// when MMIO_ARB_LOCK_EN is defined.
interface mmio_arbiter_if;
   logic        i_m0_req,    i_m1_req;
   logic [29:0] i_m0_addr,   i_m1_addr;
   logic [31:0] i_m0_data,   i_m1_data;
   logic [3:0]  i_m0_mask,   i_m1_mask;
   logic        i_m0_wren,   i_m1_wren;
`ifdef MMIO_ARB_LOCK_EN
   logic        i_m0_lock,   i_m1_lock;
`endif
   logic        o_m0_gnt,    o_m1_gnt;
   logic        o_m0_rvalid, o_m1_rvalid;
   logic [31:0] o_m0_rdata,  o_m1_rdata;
   logic [29:0] o_mmio_addr;
   logic [31:0] o_mmio_data;
   logic [3:0]  o_mmio_mask;
   logic        o_mmio_wren;
   logic [31:0] i_mmio_data;

   // arbiter side
   modport slave (
`ifdef MMIO_ARB_LOCK_EN
      input  i_m0_lock, i_m1_lock,
`endif
      input  i_m0_req, i_m0_addr, i_m0_data, i_m0_mask, i_m0_wren,
      input  i_m1_req, i_m1_addr, i_m1_data, i_m1_mask, i_m1_wren,
      output o_m0_gnt, o_m0_rvalid, o_m0_rdata,
      output o_m1_gnt, o_m1_rvalid, o_m1_rdata,
      output o_mmio_addr, o_mmio_data, o_mmio_mask, o_mmio_wren,
      input  i_mmio_data
   );

   // requesters + crossbar side
   modport master (
`ifdef MMIO_ARB_LOCK_EN
      output i_m0_lock, i_m1_lock,
`endif
      output i_m0_req, i_m0_addr, i_m0_data, i_m0_mask, i_m0_wren,
      output i_m1_req, i_m1_addr, i_m1_data, i_m1_mask, i_m1_wren,
      input  o_m0_gnt, o_m0_rvalid, o_m0_rdata,
      input  o_m1_gnt, o_m1_rvalid, o_m1_rdata,
      input  o_mmio_addr, o_mmio_data, o_mmio_mask, o_mmio_wren,
      output i_mmio_data
   );
endinterface

// File: rtl/mmio_arbiter.sv
// Two-master round-robin arbiter in front of the mmio_xbar port: IDLE -> ISSUE -> RESP.
// Optional MMIO_ARB_LOCK_EN lets the owner keep the port across back-to-back transactions.
module mmio_arbiter #(
   parameter bit FIRST_PRIO = 1'b0
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   mmio_arbiter_if.slave  bus
);
   localparam int NUM_M = 2;

   typedef struct packed {
      logic [29:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
      logic        wren;
   } mmio_req_t;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t                        state;
   logic [NUM_M-1:0]              req;
   mmio_req_t [NUM_M-1:0]         pay;
   logic                          last;
   logic                          owner;
   logic                          win;
   logic [NUM_M-1:0]              gnt;
   logic [NUM_M-1:0]              rvalid;
   logic [NUM_M-1:0][31:0]        rdata;
   mmio_req_t                     mmio;

   assign req    = {bus.i_m1_req, bus.i_m0_req};
   assign pay[0] = {bus.i_m0_addr, bus.i_m0_data, bus.i_m0_mask, bus.i_m0_wren};
   assign pay[1] = {bus.i_m1_addr, bus.i_m1_data, bus.i_m1_mask, bus.i_m1_wren};

`ifdef MMIO_ARB_LOCK_EN
   logic [NUM_M-1:0] lock;
   logic             lk_act;
   assign lock = {bus.i_m1_lock, bus.i_m0_lock};
`endif

   // Lone requester wins; contention goes to whoever was not granted last.
   always_comb begin
      win = req[1] & ~req[0];
      if (req[0] & req[1])
         win = ~last;
`ifdef MMIO_ARB_LOCK_EN
      if (lk_act && req[owner])
         win = owner;
`endif
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= IDLE;
         last   <= ~FIRST_PRIO;
         owner  <= 1'b0;
         gnt    <= '0;
         rvalid <= '0;
         rdata  <= '0;
         mmio   <= '0;
`ifdef MMIO_ARB_LOCK_EN
         lk_act <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  mmio       <= pay[win];
                  gnt[win]   <= 1'b1;
                  owner      <= win;
                  last       <= win;
`ifdef MMIO_ARB_LOCK_EN
                  lk_act     <= lock[win];
`endif
                  state      <= ISSUE;
               end else begin
`ifdef MMIO_ARB_LOCK_EN
                  lk_act     <= 1'b0;
`endif
                  state      <= IDLE;
               end
            end
            ISSUE: begin
               // Crossbar read data is combinational off o_mmio_addr, so it is valid here.
               gnt  <= '0;
               mmio <= '0;
               if (!mmio.wren) begin
                  rvalid[owner] <= 1'b1;
                  rdata[owner]  <= bus.i_mmio_data;
               end
               state <= RESP;
            end
            RESP: begin
               rvalid <= '0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_m0_gnt    = gnt[0];
   assign bus.o_m1_gnt    = gnt[1];
   assign bus.o_m0_rvalid = rvalid[0];
   assign bus.o_m1_rvalid = rvalid[1];
   assign bus.o_m0_rdata  = rdata[0];
   assign bus.o_m1_rdata  = rdata[1];
   assign bus.o_mmio_addr = mmio.addr;
   assign bus.o_mmio_data = mmio.data;
   assign bus.o_mmio_mask = mmio.mask;
   assign bus.o_mmio_wren = mmio.wren;
endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed + random bench for mmio_arbiter against a transaction-level arbitration model.
module tb_mmio_arbiter;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mmio_arbiter_if bus();

   mmio_arbiter #(.FIRST_PRIO(1'b0)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   logic [1:0]  req  = '0;
   logic [1:0]  lock = '0;
   logic [29:0] addr  [2] = '{30'h0, 30'h0};
   logic [31:0] wdata [2] = '{32'h0, 32'h0};
   logic [3:0]  mask  [2] = '{4'h0, 4'h0};
   logic        wren  [2] = '{1'b0, 1'b0};
   logic [31:0] mmio_rd = '0;

   assign bus.i_m0_req  = req[0];
   assign bus.i_m1_req  = req[1];
   assign bus.i_m0_addr = addr[0];
   assign bus.i_m1_addr = addr[1];
   assign bus.i_m0_data = wdata[0];
   assign bus.i_m1_data = wdata[1];
   assign bus.i_m0_mask = mask[0];
   assign bus.i_m1_mask = mask[1];
   assign bus.i_m0_wren = wren[0];
   assign bus.i_m1_wren = wren[1];
   assign bus.i_mmio_data = mmio_rd;
`ifdef MMIO_ARB_LOCK_EN
   assign bus.i_m0_lock = lock[0];
   assign bus.i_m1_lock = lock[1];
`endif

   int          errors = 0;
   int          checks = 0;
   int          mdl_last = 1;        // !FIRST_PRIO
   int          lk_act = 0;
   int          lk_own = 0;
   logic [31:0] exp_rdata [2] = '{32'h0, 32'h0};
   int          dut_win;
   bit          force_on = 1'b0;
   logic [31:0] force_val = '0;
   time         gnt_seen_t = 0;

   always @(posedge clk)
      if (bus.o_m0_gnt || bus.o_m1_gnt) gnt_seen_t = $time;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic quiet(input string tag);
      check({tag, "_ctl"}, {bus.o_m1_gnt, bus.o_m0_gnt, bus.o_m1_rvalid, bus.o_m0_rvalid,
                           bus.o_mmio_wren, bus.o_mmio_mask}, 64'h0);
      check({tag, "_bus"}, {bus.o_mmio_addr, bus.o_mmio_data}, 64'h0);
   endtask

   task automatic raise(input int m, input logic [29:0] a, input logic [31:0] d,
                        input logic [3:0] mk, input logic we, input logic lk);
      req[m]   = 1'b1;
      addr[m]  = a;
      wdata[m] = d;
      mask[m]  = mk;
      wren[m]  = we;
      lock[m]  = lk;
   endtask

   // One arbitration slot starting in IDLE: 1 cycle if nothing requests, else 3.
   task automatic step();
      int w;
      logic [1:0] r;
      r = req;
      @(posedge clk); #1;
      dut_win = bus.o_m1_gnt ? 1 : (bus.o_m0_gnt ? 0 : -1);
      if (r == 2'b00) begin
         quiet("idle");
         lk_act = 0;
         return;
      end
      if (r == 2'b11) w = 1 - mdl_last;
      else            w = r[1] ? 1 : 0;
`ifdef MMIO_ARB_LOCK_EN
      if (lk_act != 0 && r[lk_own]) w = lk_own;
      lk_act = int'(lock[w]);
      lk_own = w;
`endif
      mdl_last = w;
      check("gnt",       {bus.o_m1_gnt, bus.o_m0_gnt}, 64'(2'b01 << w));
      check("iss_addr",  bus.o_mmio_addr, addr[w]);
      check("iss_data",  bus.o_mmio_data, wdata[w]);
      check("iss_mask",  bus.o_mmio_mask, mask[w]);
      check("iss_wren",  bus.o_mmio_wren, wren[w]);
      check("iss_rvld",  {bus.o_m1_rvalid, bus.o_m0_rvalid}, 64'h0);
      mmio_rd = force_on ? force_val : $urandom;
      req[w]  = 1'b0;
      @(posedge clk); #1;
      check("resp_gnt",  {bus.o_m1_gnt, bus.o_m0_gnt, bus.o_mmio_wren, bus.o_mmio_mask}, 64'h0);
      check("resp_bus",  {bus.o_mmio_addr, bus.o_mmio_data}, 64'h0);
      if (!wren[w]) exp_rdata[w] = mmio_rd;
      check("rvalid",    {bus.o_m1_rvalid, bus.o_m0_rvalid}, wren[w] ? 64'h0 : 64'(2'b01 << w));
      check("rdata0",    bus.o_m0_rdata, exp_rdata[0]);
      check("rdata1",    bus.o_m1_rdata, exp_rdata[1]);
      mmio_rd = '0;
      @(posedge clk); #1;
      check("idle_rvld", {bus.o_m1_rvalid, bus.o_m0_rvalid}, 64'h0);
   endtask

   initial begin
      int  seq [4] = '{0, 1, 0, 1};
      int  lseq[4] = '{0, 0, 0, 1};
      time prev_t = 0;

      // Reset held with both masters requesting
      raise(0, 30'h0001000, 32'h11112222, 4'hF, 1'b1, 1'b0);
      raise(1, 30'h0002000, 32'h0,        4'hF, 1'b0, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
         quiet("rst");
         check("rst_rdata", {bus.o_m1_rdata, bus.o_m0_rdata}, 64'h0);
      end
      #3 rst_n = 1'b1;

      // Continuous contention: m0, m1, m0, m1, 3 cycles apart
      for (int i = 0; i < 4; i++) begin
         step();
         check("cont_order", 64'(dut_win), 64'(seq[i]));
         if (i > 0) check("cont_spacing", 64'(gnt_seen_t - prev_t), 64'd30);
         prev_t = gnt_seen_t;
         if (i == 0) raise(0, 30'h0001004, 32'h0, 4'h3, 1'b0, 1'b0);
         if (i == 1) raise(1, 30'h0002004, 32'h33334444, 4'hC, 1'b1, 1'b0);
      end

      step();   // nothing pending

      // Single write from m0
      raise(0, 30'h0DEADBE, 32'h0000BEEF, 4'b1111, 1'b1, 1'b0);
      step();
      check("wr_owner", 64'(dut_win), 64'd0);

      // Read from m1 with a fixed crossbar value
      force_on = 1'b1; force_val = 32'hCAFEF00D;
      raise(1, 30'h0000123, 32'h0, 4'hF, 1'b0, 1'b0);
      step();
      check("rd_value", bus.o_m1_rdata, 64'hCAFEF00D);
      force_on = 1'b0;

      // Reset asserted mid-ISSUE of an m0 write
      raise(0, 30'h0000777, 32'h5A5A5A5A, 4'hF, 1'b1, 1'b0);
      raise(1, 30'h0000888, 32'h0,        4'hF, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("abort_wren_pre", {bus.o_m0_gnt, bus.o_mmio_wren}, 64'h3);
      #2 rst_n = 1'b0;
      #1 quiet("abort");
      repeat (2) begin
         @(posedge clk); #1;
         quiet("abort_hold");
      end
      check("abort_rdata", {bus.o_m1_rdata, bus.o_m0_rdata}, 64'h0);
      exp_rdata[0] = '0; exp_rdata[1] = '0;
      mdl_last = 1; lk_act = 0;
      #2 rst_n = 1'b1;
      step();
      check("rearb_first", 64'(dut_win), 64'd0);
      step();
      check("rearb_second", 64'(dut_win), 64'd1);

      // Random traffic
      for (int n = 0; n < 60; n++) begin
         for (int m = 0; m < 2; m++)
            if (!req[m] && $urandom_range(0, 99) < 60)
               raise(m, 30'($urandom), $urandom, 4'($urandom), 1'($urandom_range(0, 1)),
`ifdef MMIO_ARB_LOCK_EN
                     1'($urandom_range(0, 1)));
`else
                     1'b0);
`endif
         step();
      end
      for (int k = 0; k < 10 && req != 2'b00; k++) step();
      check("drained", 64'(req), 64'h0);

`ifdef MMIO_ARB_LOCK_EN
      // m0 keeps the port while locked even though m1 is waiting
      lock = '0;
      raise(1, 30'h0000100, 32'h0, 4'hF, 1'b0, 1'b0);
      step();
      raise(1, 30'h0000104, 32'h0, 4'hF, 1'b0, 1'b0);
      raise(0, 30'h0000200, 32'h0, 4'hF, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         check("lock_order", 64'(dut_win), 64'(lseq[i]));
         if (i == 0) raise(0, 30'h0000204, 32'h0, 4'hF, 1'b0, 1'b1);
         if (i == 1) raise(0, 30'h0000208, 32'h0, 4'hF, 1'b0, 1'b0);
         if (i == 2) raise(0, 30'h000020C, 32'h0, 4'hF, 1'b0, 1'b0);
      end
      step();
      check("lock_tail", 64'(dut_win), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
